// File: rtl/nes_bus_pkg.sv
// Shared 6502 bus definitions: widths, read/write encoding, default register addresses and DMA states.
// The ALIGN2 state exists only when OAM_DMA_ODD_ALIGN_EN is defined.
package nes_bus_pkg;
  localparam int AW = 16;
  localparam int DW = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [AW-1:0] DMA_REG_ADDR_DEF = 16'h4014;
  localparam logic [AW-1:0] DEST_ADDR_DEF    = 16'h2004;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
`ifdef OAM_DMA_ODD_ALIGN_EN
    S_ALIGN2,
`endif
    S_RD,
    S_WR
  } dma_state_t;
endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and shared-bus signals of the OAM DMA controller.
// master = controller view, slave = CPU/memory view.
interface oam_dma_ctrl_if;
  import nes_bus_pkg::*;

  logic [AW-1:0] cpu_ma;
  logic [DW-1:0] cpu_do;
  logic          cpu_rw;
  logic          cpu_rdy;
  logic [DW-1:0] bus_di;
  logic [AW-1:0] bus_ma;
  logic [DW-1:0] bus_do;
  logic          bus_rw;
  logic          dma_busy;
  logic          dma_done;

  modport master (
    input  cpu_ma, cpu_do, cpu_rw, bus_di,
    output cpu_rdy, bus_ma, bus_do, bus_rw, dma_busy, dma_done
  );

  modport slave (
    output cpu_ma, cpu_do, cpu_rw, bus_di,
    input  cpu_rdy, bus_ma, bus_do, bus_rw, dma_busy, dma_done
  );
endinterface

// File: rtl/nes_bus_mux.sv
// Shared-bus owner select: CPU drives the bus unless a DMA engine owns it.
// Purely combinational; also intended for the DMC sample DMA.
module nes_bus_mux
  import nes_bus_pkg::*;
(
  input  logic          i_dma_owns,
  input  logic [AW-1:0] i_cpu_ma,
  input  logic [DW-1:0] i_cpu_do,
  input  logic          i_cpu_rw,
  input  logic [AW-1:0] i_dma_ma,
  input  logic [DW-1:0] i_dma_do,
  input  logic          i_dma_rw,
  output logic [AW-1:0] o_bus_ma,
  output logic [DW-1:0] o_bus_do,
  output logic          o_bus_rw
);
  assign o_bus_ma = i_dma_owns ? i_dma_ma : i_cpu_ma;
  assign o_bus_do = i_dma_owns ? i_dma_do : i_cpu_do;
  assign o_bus_rw = i_dma_owns ? i_dma_rw : i_cpu_rw;
endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: a CPU write to DMA_REG_ADDR stalls the CPU and copies LEN bytes from {page, idx} to DEST_ADDR.
// Optional OAM_DMA_ODD_ALIGN_EN adds a second dummy cycle when alignment starts on an odd cycle.
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [AW-1:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
  parameter logic [AW-1:0] DEST_ADDR    = DEST_ADDR_DEF,
  parameter int unsigned   LEN          = 256
) (
  input  logic clk,
  input  logic reset,
  oam_dma_ctrl_if.master io
);
  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

  dma_state_t    r_state;
  dma_state_t    w_state_nxt;
  logic [7:0]    r_page;
  logic [7:0]    r_idx;
  logic [DW-1:0] r_data;
  logic          r_cpu_rdy;
  logic          r_busy;
  logic          r_done;
`ifdef OAM_DMA_ODD_ALIGN_EN
  logic          r_par;
`endif

  logic          w_dma_owns;
  logic [AW-1:0] w_dma_ma;
  logic          w_dma_rw;
  logic          w_trigger;
  logic          w_rd_en;
  logic          w_step;
  logic          w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dma_owns  = 1'b0;
    w_dma_ma    = io.cpu_ma;
    w_dma_rw    = RW_READ;
    w_trigger   = 1'b0;
    w_rd_en     = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (io.cpu_rw == RW_WRITE && io.cpu_ma == DMA_REG_ADDR) begin
          w_trigger   = 1'b1;
          w_state_nxt = S_HALT;
        end
      end
      // rdy cannot stop a 6502 write cycle, so wait for the first read
      S_HALT: begin
        if (io.cpu_rw == RW_READ) w_state_nxt = S_ALIGN;
      end
      S_ALIGN: begin
        w_dma_owns = 1'b1;
`ifdef OAM_DMA_ODD_ALIGN_EN
        w_state_nxt = r_par ? S_ALIGN2 : S_RD;
`else
        w_state_nxt = S_RD;
`endif
      end
`ifdef OAM_DMA_ODD_ALIGN_EN
      S_ALIGN2: begin
        w_dma_owns  = 1'b1;
        w_state_nxt = S_RD;
      end
`endif
      S_RD: begin
        w_dma_owns  = 1'b1;
        w_dma_ma    = {r_page, r_idx};
        w_rd_en     = 1'b1;
        w_state_nxt = S_WR;
      end
      S_WR: begin
        w_dma_owns = 1'b1;
        w_dma_ma   = DEST_ADDR;
        w_dma_rw   = RW_WRITE;
        if (r_idx == LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_step      = 1'b1;
          w_state_nxt = S_RD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_page    <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_cpu_rdy <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_trigger) begin
        r_page <= io.cpu_do;
        r_idx  <= '0;
      end
      if (w_rd_en) r_data <= io.bus_di;
      // idx stays within the page; it returns to 0 only at completion
      if (w_step)      r_idx <= r_idx + 8'd1;
      else if (w_last) r_idx <= '0;
      r_cpu_rdy <= (w_state_nxt == S_IDLE);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= w_last;
    end
  end

`ifdef OAM_DMA_ODD_ALIGN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_par <= 1'b0;
    else       r_par <= ~r_par;
  end
`endif

  nes_bus_mux u_mux (
    .i_dma_owns (w_dma_owns),
    .i_cpu_ma   (io.cpu_ma),
    .i_cpu_do   (io.cpu_do),
    .i_cpu_rw   (io.cpu_rw),
    .i_dma_ma   (w_dma_ma),
    .i_dma_do   (r_data),
    .i_dma_rw   (w_dma_rw),
    .o_bus_ma   (io.bus_ma),
    .o_bus_do   (io.bus_do),
    .o_bus_rw   (io.bus_rw)
  );

  assign io.cpu_rdy  = r_cpu_rdy;
  assign io.dma_busy = r_busy;
  assign io.dma_done = r_done;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: scripted and random transfers checked against a cycle-offset transfer model.
// Honours OAM_DMA_ODD_ALIGN_EN when computing the expected alignment delay.
module tb_oam_dma_ctrl;
  import nes_bus_pkg::*;

  localparam int LEN = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oam_dma_ctrl_if io();
  logic [7:0] mem [0:65535];
  assign io.bus_di = mem[io.bus_ma];

  oam_dma_ctrl #(
    .DMA_REG_ADDR (16'h4014),
    .DEST_ADDR    (16'h2004),
    .LEN          (LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int total = 0;
  int bad   = 0;
  int cyc;

  // cycle parity reference: edges seen since reset released
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [15:0] ma, input logic [7:0] d);
    io.cpu_rw = rw;
    io.cpu_ma = ma;
    io.cpu_do = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive(1'b1, 16'h8000, 8'h00);
    end
  endtask

  // Trigger at offset 0, n_wr CPU pushes, then a frozen CPU read; optionally hammer $4014 mid-transfer.
  task automatic run_xfer(input logic [7:0] page, input int n_wr, input bit inject);
    logic [15:0] t_ma[$];
    logic        t_rw[$];
    logic [7:0]  t_do[$];
    logic        t_rdy[$];
    logic        t_busy[$];
    logic        t_done[$];
    int          t_cyc[$];
    int off, extra, base, done_off, e_pass, e_rd, e_wr, nlow, nbusy, ndone, last;
    logic [15:0] ema;
    logic [7:0]  edo;
    bit done_seen;
    off = 0;
    done_seen = 1'b0;
    while (!done_seen && off < 700) begin
      @(posedge clk); #1;
      if (off == 0)
        drive(1'b0, 16'h4014, page);
      else if (off <= n_wr)
        drive(1'b0, 16'(16'h01FE - off), 8'(8'hC0 + off));
      else if (inject && off >= n_wr + 6 && off < n_wr + 300)
        drive(1'b0, 16'h4014, 8'h07);
      else
        drive(1'b1, 16'h8000, 8'h00);
      @(negedge clk);
      t_ma.push_back(io.bus_ma);
      t_rw.push_back(io.bus_rw);
      t_do.push_back(io.bus_do);
      t_rdy.push_back(io.cpu_rdy);
      t_busy.push_back(io.dma_busy);
      t_done.push_back(io.dma_done);
      t_cyc.push_back(cyc);
      if (io.dma_done === 1'b1) done_seen = 1'b1;
      off++;
    end

    extra = 0;
`ifdef OAM_DMA_ODD_ALIGN_EN
    if (t_cyc.size() > n_wr + 2) extra = t_cyc[n_wr + 2] % 2;
`endif
    base     = n_wr + 3 + extra;
    done_off = base + 2 * LEN;
    last     = t_ma.size() - 1;

    check("done_seen", 32'(done_seen), 1);
    check("done_offset", last, done_off);

    e_pass = 0;
    for (int k = 0; k <= n_wr; k++) begin
      ema = (k == 0) ? 16'h4014 : 16'(16'h01FE - k);
      edo = (k == 0) ? page : 8'(8'hC0 + k);
      if (k > last || t_ma[k] !== ema || t_rw[k] !== 1'b0 || t_do[k] !== edo) e_pass++;
    end
    check("cpu_writes_pass", e_pass, 0);
    if (n_wr + 2 <= last) check("align_dummy", {t_rw[n_wr + 2], t_ma[n_wr + 2]}, {1'b1, 16'h8000});
    else                  check("align_dummy", 32'hFFFF_FFFF, {1'b1, 16'h8000});

    e_rd = 0;
    e_wr = 0;
    for (int i = 0; i < LEN; i++) begin
      int r;
      logic [15:0] src;
      r   = base + 2 * i;
      src = {page, 8'(i)};
      if (r + 1 > last) begin
        e_rd++;
        e_wr++;
      end else begin
        if (t_ma[r] !== src || t_rw[r] !== 1'b1) e_rd++;
        if (t_ma[r + 1] !== 16'h2004 || t_rw[r + 1] !== 1'b0 || t_do[r + 1] !== mem[src]) e_wr++;
      end
    end
    check("first_rd_addr", (base <= last) ? 32'(t_ma[base]) : 32'hFFFF_FFFF, {page, 8'h00});
    check("rd_sequence", e_rd, 0);
    check("wr_sequence", e_wr, 0);

    nlow  = 0;
    nbusy = 0;
    ndone = 0;
    for (int k = 0; k <= last; k++) begin
      if (t_rdy[k] !== 1'b1)  nlow++;
      if (t_busy[k] === 1'b1) nbusy++;
      if (t_done[k] === 1'b1) ndone++;
    end
    check("rdy_low_cycles", nlow, (n_wr + 1) + (1 + 2 * LEN + extra));
    check("busy_cycles", nbusy, done_off - 1);
    check("done_pulses", ndone, 1);
    check("end_rdy_busy", {t_rdy[last], t_busy[last]}, 2'b10);
  endtask

  task automatic reset_mid(input logic [7:0] page);
    int nwr, off, nlow;
    nwr = 0;
    off = 0;
    while (nwr < 'h41 && off < 700) begin
      @(posedge clk); #1;
      if (off == 0) drive(1'b0, 16'h4014, page);
      else          drive(1'b1, 16'h8000, 8'h00);
      @(negedge clk);
      if (io.bus_rw === 1'b0 && io.bus_ma === 16'h2004) nwr++;
      off++;
    end
    check("rst_reach_idx40", nwr, 'h41);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 16'h8000, 8'h00);
    #1;
    check("rst_rdy", 32'(io.cpu_rdy), 1);
    check("rst_busy", 32'(io.dma_busy), 0);
    check("rst_bus_pass", {io.bus_rw, io.bus_ma}, {1'b1, 16'h8000});
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    nwr  = 0;
    nlow = 0;
    repeat (40) begin
      @(negedge clk);
      if (io.bus_rw === 1'b0 && io.bus_ma === 16'h2004) nwr++;
      if (io.cpu_rdy !== 1'b1) nlow++;
    end
    check("post_rst_oam_wr", nwr, 0);
    check("post_rst_rdy_low", nlow, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 16'h1234, 8'hAB);
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

    repeat (2) @(negedge clk);
    check("reset_rdy", 32'(io.cpu_rdy), 1);
    check("reset_busy", 32'(io.dma_busy), 0);
    check("reset_done", 32'(io.dma_done), 0);
    check("reset_bus_pass", {io.bus_rw, io.bus_do, io.bus_ma}, {1'b0, 8'hAB, 16'h1234});

    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b1, 16'h8000, 8'h00);
    idle(3);

    run_xfer(8'h02, 0, 1'b0);
    idle(2);
    run_xfer(8'($urandom), 3, 1'b0);
    run_xfer(8'h03, 0, 1'b0);
    idle(1);
    run_xfer(8'h05, 1, 1'b1);
    reset_mid(8'h08);
    idle(3);
    run_xfer(8'h0A, 0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      idle($urandom_range(0, 4));
      run_xfer(8'($urandom), $urandom_range(0, 3), 1'($urandom));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
